anti_jitter: RTL

ANTI_JITTER -- requirements
Module: anti_jitter

---
 rtl/anti_jitter_if.sv | 23 ++
 rtl/anti_jitter.sv | 86 ++++++++
 2 files changed

// File: rtl/anti_jitter_if.sv
// Raw button/switch levels and the sample-rate divider bit in, debounced levels, press strobes and the sample tick out.
interface anti_jitter_if #(
  parameter int N_BTN = 5,
  parameter int N_SW  = 16
);
  logic             clkdiv_bit;
  logic [N_BTN-1:0] btn_in;
  logic [N_SW-1:0]  sw_in;
  logic [N_BTN-1:0] btn_out;
  logic [N_BTN-1:0] btn_pulse;
  logic [N_SW-1:0]  sw_out;
  logic             tick;

  modport master (
    output clkdiv_bit, btn_in, sw_in,
    input  btn_out, btn_pulse, sw_out, tick
  );

  modport slave (
    input  clkdiv_bit, btn_in, sw_in,
    output btn_out, btn_pulse, sw_out, tick
  );
endinterface

// File: rtl/anti_jitter.sv
// Debouncer for push buttons and slide switches. Each channel is synchronised,
// then sampled on every rising edge of a divider bit; a new level is accepted
// only after STABLE_CNT consecutive samples that disagree with the current output.
// Channels [N_BTN-1:0] are buttons, the rest are switches.
module anti_jitter #(
  parameter int N_BTN      = 5,
  parameter int N_SW       = 16,
  parameter int STABLE_CNT = 4
) (
  input logic         clk,
  input logic         rst,
  anti_jitter_if.slave bus
);

  localparam int N = N_BTN + N_SW;
  localparam logic [3:0] LAST = 4'(STABLE_CNT - 1);

  logic [N-1:0]     sync1;
  logic [N-1:0]     sync2;
  logic [N-1:0]     out;
  logic [3:0]       cnt [N];
  logic             cb_d;
  logic             tick;
  logic [N_BTN-1:0] btn_prev;
  logic [N_BTN-1:0] pulse;

  // Two-flop synchroniser for every raw input channel.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= {bus.sw_in, bus.btn_in};
      sync2 <= sync1;
    end
  end

  // Registered one-cycle strobe on each rising edge of the divider bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cb_d <= 1'b0;
      tick <= 1'b0;
    end else begin
      cb_d <= bus.clkdiv_bit;
      tick <= bus.clkdiv_bit & ~cb_d;
    end
  end

  // Per-channel mismatch counters; any agreeing sample restarts qualification.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out <= '0;
      for (int unsigned i = 0; i < N; i++) cnt[i] <= '0;
    end else if (tick) begin
      for (int unsigned i = 0; i < N; i++) begin
        if (sync2[i] != out[i]) begin
          if (cnt[i] == LAST) begin
            out[i] <= sync2[i];
            cnt[i] <= '0;
          end else begin
            cnt[i] <= cnt[i] + 4'd1;
          end
        end else begin
          cnt[i] <= '0;
        end
      end
    end
  end

  // Press strobe: one cycle after a debounced button rises.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      btn_prev <= '0;
      pulse    <= '0;
    end else begin
      btn_prev <= out[N_BTN-1:0];
      pulse    <= out[N_BTN-1:0] & ~btn_prev;
    end
  end

  assign bus.btn_out   = out[N_BTN-1:0];
  assign bus.sw_out    = out[N-1:N_BTN];
  assign bus.btn_pulse = pulse;
  assign bus.tick      = tick;

endmodule
